// File: rtl/cell_alu_pipe.sv
// Run-length cell ALU (INC/DEC by count, CLR, PASS) with wrap/saturate arithmetic,
// followed by a 2-entry skid buffer and overflow/transfer status registers.
module cell_alu_pipe #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 8,
  parameter int OPCNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         op_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic               sat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               overflow_o,
  output logic               ovf_sticky_o,
  input  logic               clr_sticky_i,
  output logic [OPCNT_W-1:0] op_count_o
);

  generate
    if (COUNT_W > DATA_W) begin : g_bad_count_w
      $error("cell_alu_pipe: COUNT_W must not exceed DATA_W");
    end
  endgenerate

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  logic [DATA_W:0]   step_ext;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_ovf;

  always_comb begin
    step_ext = (count_i == '0) ? {{DATA_W{1'b0}}, 1'b1}
                               : {{(DATA_W + 1 - COUNT_W){1'b0}}, count_i};
    sum        = {1'b0, data_i} + step_ext;
    diff       = {1'b0, data_i} - step_ext;
    alu_result = data_i;
    alu_ovf    = 1'b0;
    case (op_i)
      OP_INC: begin
        alu_ovf    = sum[DATA_W];
        alu_result = (sat_i && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
      end
      OP_DEC: begin
        alu_ovf    = diff[DATA_W];
        alu_result = (sat_i && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
      end
      OP_CLR:  alu_result = '0;
      default: alu_result = data_i;
    endcase
    alu_zero = (alu_result == '0);
  end

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_result_q, main_result_d;
  logic              main_zero_q, main_zero_d;
  logic              main_ovf_q, main_ovf_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_result_q, skid_result_d;
  logic              skid_zero_q, skid_zero_d;
  logic              skid_ovf_q, skid_ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              sticky_q, sticky_d;
  logic [OPCNT_W-1:0] opcnt_q, opcnt_d;

  logic in_fire;
  logic out_fire;

  always_comb begin
    in_fire  = in_valid_i & in_ready_q;
    out_fire = main_valid_q & out_ready_i;

    main_valid_d  = main_valid_q;
    main_result_d = main_result_q;
    main_zero_d   = main_zero_q;
    main_ovf_d    = main_ovf_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_zero_d   = skid_zero_q;
    skid_ovf_d    = skid_ovf_q;

    if (out_fire || !main_valid_q) begin
      // Main slot frees up: skid has priority (input is blocked while it is full).
      if (skid_valid_q) begin
        main_valid_d  = 1'b1;
        main_result_d = skid_result_q;
        main_zero_d   = skid_zero_q;
        main_ovf_d    = skid_ovf_q;
        skid_valid_d  = 1'b0;
      end else if (in_fire) begin
        main_valid_d  = 1'b1;
        main_result_d = alu_result;
        main_zero_d   = alu_zero;
        main_ovf_d    = alu_ovf;
      end else begin
        main_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d  = 1'b1;
      skid_result_d = alu_result;
      skid_zero_d   = alu_zero;
      skid_ovf_d    = alu_ovf;
    end

    in_ready_d = !skid_valid_d;

    sticky_d = sticky_q;
    if (out_fire && main_ovf_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end

    opcnt_d = out_fire ? opcnt_q + 1'b1 : opcnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q  <= 1'b0;
      main_result_q <= '0;
      main_zero_q   <= 1'b0;
      main_ovf_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_zero_q   <= 1'b0;
      skid_ovf_q    <= 1'b0;
      in_ready_q    <= 1'b1;
      sticky_q      <= 1'b0;
      opcnt_q       <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      main_result_q <= main_result_d;
      main_zero_q   <= main_zero_d;
      main_ovf_q    <= main_ovf_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_zero_q   <= skid_zero_d;
      skid_ovf_q    <= skid_ovf_d;
      in_ready_q    <= in_ready_d;
      sticky_q      <= sticky_d;
      opcnt_q       <= opcnt_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = main_valid_q;
  assign result_o     = main_result_q;
  assign zero_o       = main_zero_q;
  assign overflow_o   = main_ovf_q;
  assign ovf_sticky_o = sticky_q;
  assign op_count_o   = opcnt_q;

endmodule

// File: tb/tb_cell_alu_pipe.sv
// Bench for cell_alu_pipe: directed and random ops checked against an occupancy/queue
// reference model with integer arithmetic for the ALU rules.
module tb_cell_alu_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  count_i = 8'h00;
  logic        sat_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [7:0]  result_o;
  logic        zero_o;
  logic        overflow_o;
  logic        ovf_sticky_o;
  logic        clr_sticky_i = 1'b0;
  logic [15:0] op_count_o;

  cell_alu_pipe #(.DATA_W(8), .COUNT_W(8), .OPCNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .data_i(data_i), .count_i(count_i), .sat_i(sat_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o),
    .ovf_sticky_o(ovf_sticky_o), .clr_sticky_i(clr_sticky_i),
    .op_count_o(op_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: pending results {result, zero, ovf} in order, plus status.
  logic [9:0]  exp_q[$];
  logic        exp_sticky = 1'b0;
  logic [15:0] exp_cnt = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_alu(input logic [1:0] op, input logic [7:0] d,
                                         input logic [7:0] c, input logic s);
    int step, v, r;
    bit ov;
    step = (c == 0) ? 1 : int'(c);
    r = int'(d);
    ov = 1'b0;
    if (op == 2'd0) begin
      v = int'(d) + step;
      ov = (v > 255);
      r = ov ? (s ? 255 : v - 256) : v;
    end else if (op == 2'd1) begin
      v = int'(d) - step;
      ov = (v < 0);
      r = ov ? (s ? 0 : v + 256) : v;
    end else if (op == 2'd2) begin
      r = 0;
    end
    return {r[7:0], (r == 0), ov};
  endfunction

  task automatic check_all();
    chk("out_valid", out_valid_o, exp_q.size() > 0);
    chk("in_ready", in_ready_o, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      chk("result", result_o, exp_q[0][9:2]);
      chk("zero", zero_o, exp_q[0][1]);
      chk("overflow", overflow_o, exp_q[0][0]);
    end
    chk("sticky", ovf_sticky_o, exp_sticky);
    chk("op_count", op_count_o, exp_cnt);
  endtask

  // One clock: drive inputs, advance model at the edge, check outputs 1 time unit later.
  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] d,
                      input logic [7:0] c, input bit s, input bit rdy, input bit clr,
                      output bit acc);
    bit oute;
    logic [9:0] e;
    in_valid_i = v;
    op_i = v ? op : 2'($urandom);
    data_i = v ? d : 8'($urandom);
    count_i = v ? c : 8'($urandom);
    sat_i = v ? s : 1'($urandom);
    out_ready_i = rdy;
    clr_sticky_i = clr;
    @(posedge clk);
    acc = v && (exp_q.size() < 2);
    oute = rdy && (exp_q.size() > 0);
    if (oute) begin
      e = exp_q.pop_front();
      exp_cnt = exp_cnt + 16'd1;
      if (e[0]) exp_sticky = 1'b1;
      else if (clr) exp_sticky = 1'b0;
    end else if (clr) begin
      exp_sticky = 1'b0;
    end
    if (acc) exp_q.push_back(ref_alu(op, d, c, s));
    #1;
    $display("step v=%0b op=%0d d=%02h c=%02h s=%0b rdy=%0b clr=%0b -> ov=%0b res=%02h z=%0b o=%0b st=%0b cnt=%0d",
             v, op, d, c, s, rdy, clr, out_valid_o, result_o, zero_o, overflow_o,
             ovf_sticky_o, op_count_o);
    check_all();
  endtask

  logic [1:0] t3_op[4];
  logic [7:0] t3_d[4];
  logic [15:0] cnt_before;

  initial begin
    bit acc;
    int idx;
    int guard;

    // Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_result", result_o, 8'h00);
    chk("rst_zero", zero_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_sticky", ovf_sticky_o, 1'b0);
    chk("rst_count", op_count_o, 16'h0000);

    // Test 1
    step(1, 2'd0, 8'hFE, 8'h01, 0, 1, 0, acc);
    chk("t1a_result", result_o, 8'hFF);
    chk("t1a_zero", zero_o, 1'b0);
    chk("t1a_ovf", overflow_o, 1'b0);
    step(1, 2'd0, 8'hFF, 8'h00, 0, 1, 0, acc);
    chk("t1b_result", result_o, 8'h00);
    chk("t1b_zero", zero_o, 1'b1);
    chk("t1b_ovf", overflow_o, 1'b1);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);
    chk("t1b_sticky", ovf_sticky_o, 1'b1);

    // Test 2
    step(1, 2'd0, 8'hF0, 8'h20, 1, 1, 0, acc);
    chk("t2a_result", result_o, 8'hFF);
    chk("t2a_ovf", overflow_o, 1'b1);
    step(1, 2'd1, 8'h05, 8'h09, 1, 1, 0, acc);
    chk("t2b_result", result_o, 8'h00);
    chk("t2b_ovf", overflow_o, 1'b1);
    chk("t2b_zero", zero_o, 1'b1);
    step(1, 2'd1, 8'h05, 8'h09, 0, 1, 0, acc);
    chk("t2c_result", result_o, 8'hFC);
    chk("t2c_ovf", overflow_o, 1'b1);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Test 3: back-pressure
    for (int i = 0; i < 4; i++) begin
      t3_op[i] = 2'(i);
      t3_d[i] = 8'(8'h40 + 8'(i * 16));
    end
    cnt_before = exp_cnt;
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step(idx < 4, t3_op[idx % 4], t3_d[idx % 4], 8'h03, 0, cyc >= 3, 0, acc);
      if (acc && idx == 1) begin
        // Skid just took the 2nd op; ready must drop for the following cycle.
        chk("t3_ready_low", in_ready_o, 1'b0);
      end
      if (acc) idx++;
    end
    chk("t3_all_accepted", idx, 4);
    chk("t3_op_count", op_count_o, cnt_before + 16'd4);

    // Test 4: streaming random ops
    for (int i = 0; i < 100; i++) begin
      step(1, 2'($urandom), 8'($urandom), 8'($urandom_range(0, 15)), 1'($urandom), 1, 0, acc);
      chk("t4_accept", acc, 1'b1);
    end
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Test 5: reset with both entries full and sticky set
    step(1, 2'd0, 8'hFF, 8'h05, 0, 0, 0, acc);
    step(1, 2'd1, 8'h00, 8'h01, 0, 0, 0, acc);
    step(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, acc);
    chk("t5_full", in_ready_o, 1'b0);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);
    chk("t5_sticky_pre", ovf_sticky_o, 1'b1);
    step(1, 2'd2, 8'h11, 8'h01, 0, 0, 0, acc);
    step(0, 2'd0, 8'h00, 8'h00, 0, 0, 0, acc);
    chk("t5_full2", in_ready_o, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5_out_valid", out_valid_o, 1'b0);
    chk("t5_in_ready", in_ready_o, 1'b1);
    chk("t5_sticky", ovf_sticky_o, 1'b0);
    chk("t5_count", op_count_o, 16'h0000);
    exp_q.delete();
    exp_sticky = 1'b0;
    exp_cnt = 16'h0000;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1, 0, acc);
    chk("t5_first_valid", out_valid_o, 1'b1);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);

    // Test 6: set beats clear, then clear alone, then counter wrap
    step(1, 2'd0, 8'hFF, 8'h01, 0, 0, 0, acc);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 1, acc);
    chk("t6_set_wins", ovf_sticky_o, 1'b1);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 1, acc);
    chk("t6_clear", ovf_sticky_o, 1'b0);
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      step((32'(exp_cnt) + exp_q.size()) < 32'hFFFF, 2'd3, 8'(guard), 8'h00, 0, 1, 0, acc);
      guard++;
    end
    chk("t6_preload_done", exp_cnt, 16'hFFFF);
    chk("t6_count_ffff", op_count_o, 16'hFFFF);
    step(1, 2'd3, 8'h5A, 8'h00, 0, 1, 0, acc);
    step(0, 2'd0, 8'h00, 8'h00, 0, 1, 0, acc);
    chk("t6_count_wrap", op_count_o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
